alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 41 ++++
 rtl/alu_arbiter_alu.sv | 50 +++++
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: op-code encodings, the illegal-op list and the
// response-buffer state type used by the arbiter.
package alu_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned FLAG_W = 5;

  // ALU control codes. 4'h9, 4'hC and 4'hE are unassigned and treated as illegal.
  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLTU  = 4'h8,
    OP_NOR   = 4'hA,
    OP_PASSB = 4'hB,
    OP_SRA   = 4'hD,
    OP_PASSA = 4'hF
  } alu_op_e;

  localparam logic [3:0] ILLEGAL_OPS [3] = '{4'h9, 4'hC, 4'hE};

  function automatic logic is_illegal_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (op == ILLEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: shared combinational datapath.
//   a, b  : 32-bit operands
//   op    : 4-bit ALU control code
//   res   : 32-bit result (0 for illegal op codes)
//   flags : {eq, gteu, ltu, gtes, lts} operand comparison (0 for illegal op codes)
//   err   : op code is illegal
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [3:0]        op,
  output logic [XLEN-1:0]   res,
  output logic [FLAG_W-1:0] flags,
  output logic              err
);

  logic [XLEN-1:0] raw;
  logic [4:0]      shamt;

  always_comb begin
    raw   = '0;
    shamt = b[4:0];
    case (op)
      OP_ADD:   raw = a + b;
      OP_SUB:   raw = a - b;
      OP_AND:   raw = a & b;
      OP_OR:    raw = a | b;
      OP_XOR:   raw = a ^ b;
      OP_SLL:   raw = a << shamt;
      OP_SRL:   raw = a >> shamt;
      OP_SLT:   raw = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  raw = {{(XLEN-1){1'b0}}, a < b};
      OP_NOR:   raw = ~(a | b);
      OP_PASSB: raw = b;
      OP_SRA:   raw = $unsigned($signed(a) >>> shamt);
      OP_PASSA: raw = a;
      default:  raw = '0;
    endcase

    err   = is_illegal_op(op);
    flags = {a == b, a >= b, a < b, $signed(a) >= $signed(b), $signed(a) < $signed(b)};
    res   = raw;
    if (err) begin
      res   = '0;
      flags = '0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end to a shared ALU with a
// one-entry response buffer (valid/ready on both sides, 1-cycle latency).
//   clk_w_i / rst_w_i_h          : clock, synchronous active-high reset
//   reqN_valid/a/b/op            : request N operation (N = 0, 1)
//   reqN_ready_w_o_h             : request N accepted this cycle
//   rsp_valid/id/res/flags/err   : buffered result and its owner
//   rsp_ready_w_i_h              : consumer takes the response this cycle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk_w_i,
  input  logic              rst_w_i_h,
  input  logic              req0_valid_w_i_h,
  input  logic [XLEN-1:0]   req0_a_w_i,
  input  logic [XLEN-1:0]   req0_b_w_i,
  input  logic [3:0]        req0_op_w_i,
  output logic              req0_ready_w_o_h,
  input  logic              req1_valid_w_i_h,
  input  logic [XLEN-1:0]   req1_a_w_i,
  input  logic [XLEN-1:0]   req1_b_w_i,
  input  logic [3:0]        req1_op_w_i,
  output logic              req1_ready_w_o_h,
  output logic              rsp_valid_w_o_h,
  output logic              rsp_id_w_o,
  output logic [XLEN-1:0]   rsp_res_w_o,
  output logic [FLAG_W-1:0] rsp_flags_w_o,
  output logic              rsp_err_w_o_h,
  input  logic              rsp_ready_w_i_h
);

  buf_state_e        state_q, state_d;
  logic              prio_q;
  logic              id_q;
  logic [XLEN-1:0]   res_q;
  logic [FLAG_W-1:0] flags_q;
  logic              err_q;

  logic              can_accept, grant0, grant1, accept, sel_id;
  logic [XLEN-1:0]   alu_a, alu_b, alu_res;
  logic [3:0]        alu_op;
  logic [FLAG_W-1:0] alu_flags;
  logic              alu_err;

  always_comb begin
    can_accept = (state_q == BUF_EMPTY) || rsp_ready_w_i_h;
    grant0     = req0_valid_w_i_h && (!req1_valid_w_i_h || !prio_q);
    grant1     = req1_valid_w_i_h && (!req0_valid_w_i_h ||  prio_q);
    // Reset gates acceptance so the handshake outputs stay low in reset cycles.
    accept     = (grant0 || grant1) && can_accept && !rst_w_i_h;
    sel_id     = grant1;

    alu_a  = sel_id ? req1_a_w_i  : req0_a_w_i;
    alu_b  = sel_id ? req1_b_w_i  : req0_b_w_i;
    alu_op = sel_id ? req1_op_w_i : req0_op_w_i;

    state_d = state_q;
    if (accept) begin
      state_d = BUF_FULL;
    end else if (state_q == BUF_FULL && rsp_ready_w_i_h) begin
      state_d = BUF_EMPTY;
    end

    req0_ready_w_o_h = grant0 && can_accept && !rst_w_i_h;
    req1_ready_w_o_h = grant1 && can_accept && !rst_w_i_h;
    rsp_valid_w_o_h  = (state_q == BUF_FULL) && !rst_w_i_h;
  end

  alu u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .res   (alu_res),
    .flags (alu_flags),
    .err   (alu_err)
  );

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q <= BUF_EMPTY;
      prio_q  <= RR_INIT;
      id_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        prio_q  <= ~sel_id;
        id_q    <= sel_id;
        res_q   <= alu_res;
        flags_q <= alu_flags;
        err_q   <= alu_err;
      end
    end
  end

  assign rsp_id_w_o    = id_q;
  assign rsp_res_w_o   = res_q;
  assign rsp_flags_w_o = flags_q;
  assign rsp_err_w_o_h = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1, rr;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_res;
  logic [4:0]  rsp_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk_w_i          (clk),
    .rst_w_i_h        (rst),
    .req0_valid_w_i_h (v0),
    .req0_a_w_i       (a0),
    .req0_b_w_i       (b0),
    .req0_op_w_i      (op0),
    .req0_ready_w_o_h (rdy0),
    .req1_valid_w_i_h (v1),
    .req1_a_w_i       (a1),
    .req1_b_w_i       (b1),
    .req1_op_w_i      (op1),
    .req1_ready_w_o_h (rdy1),
    .rsp_valid_w_o_h  (rsp_valid),
    .rsp_id_w_o       (rsp_id),
    .rsp_res_w_o      (rsp_res),
    .rsp_flags_w_o    (rsp_flags),
    .rsp_err_w_o_h    (rsp_err),
    .rsp_ready_w_i_h  (rr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: buffer occupancy, priority holder and buffered contents.
  logic        m_full  = 1'b0;
  logic        m_prio  = 1'b0;
  logic        m_id    = 1'b0;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_flags = '0;
  logic        m_err   = 1'b0;
  logic        last_r0, last_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f, output logic e);
    int unsigned sh;
    sh = b % 32;
    e  = (op == 4'd9) || (op == 4'd12) || (op == 4'd14);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = ~(a | b);
      4'd11: r = b;
      4'd13: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd15: r = a;
      default: r = 32'd0;
    endcase
    f = {a == b, a >= b, a < b, int'(a) >= int'(b), int'(a) < int'(b)};
    if (e) begin
      r = 32'd0;
      f = 5'd0;
    end
  endfunction

  task automatic step(input logic s_rst,
                      input logic s_v0, input logic [3:0] s_op0, input logic [31:0] s_a0, input logic [31:0] s_b0,
                      input logic s_v1, input logic [3:0] s_op1, input logic [31:0] s_a1, input logic [31:0] s_b1,
                      input logic s_rr);
    logic e0, e1;
    @(negedge clk);
    rst = s_rst; v0 = s_v0; op0 = s_op0; a0 = s_a0; b0 = s_b0;
    v1 = s_v1; op1 = s_op1; a1 = s_a1; b1 = s_b1; rr = s_rr;
    #1;
    e0 = !s_rst && s_v0 && (!s_v1 || m_prio == 1'b0) && (!m_full || s_rr);
    e1 = !s_rst && s_v1 && (!s_v0 || m_prio == 1'b1) && (!m_full || s_rr);
    chk("ready0", 32'(rdy0), 32'(e0));
    chk("ready1", 32'(rdy1), 32'(e1));
    chk("valid_pre", 32'(rsp_valid), 32'(!s_rst && m_full));
    last_r0 = rdy0;
    last_r1 = rdy1;
    @(posedge clk);
    if (s_rst) begin
      m_full = 1'b0; m_prio = 1'b0; m_id = 1'b0; m_res = '0; m_flags = '0; m_err = 1'b0;
    end else if (e0 || e1) begin
      m_id = e1;
      if (e1) ref_alu(s_op1, s_a1, s_b1, m_res, m_flags, m_err);
      else    ref_alu(s_op0, s_a0, s_b0, m_res, m_flags, m_err);
      m_full = 1'b1;
      m_prio = !m_id;
    end else if (m_full && s_rr) begin
      m_full = 1'b0;
    end
    #1;
    chk("valid", 32'(rsp_valid), 32'(m_full && !s_rst));
    chk("id",    32'(rsp_id),    32'(m_id));
    chk("res",   rsp_res,        m_res);
    chk("flags", 32'(rsp_flags), 32'(m_flags));
    chk("err",   32'(rsp_err),   32'(m_err));
  endtask

  task automatic idle(input logic s_rst, input logic s_rr);
    step(s_rst, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, s_rr);
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;

    // Reset state
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_res", rsp_res, 32'd0);

    // req0 ADD 5+7
    step(1'b0, 1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_res", rsp_res, 32'd12);
    chk("add_err", 32'(rsp_err), 32'd0);

    // Both valid every cycle from reset: grants alternate 0,1,0,1 with no bubble
    idle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd0, 32'(i), 32'd100, 1'b1, 4'd1, 32'd50, 32'(i), 1'b1);
      chk("alt_ready0", 32'(last_r0), 32'(i % 2 == 0));
      chk("alt_ready1", 32'(last_r1), 32'(i % 2 == 1));
      chk("alt_valid", 32'(rsp_valid), 32'd1);
      chk("alt_id", 32'(rsp_id), 32'(i % 2));
    end

    // req1 SUB 3-3 held while consumer stalls; req0 waits
    idle(1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'd3, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'd0, 32'd9, 32'd9, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("stall_ready0", 32'(last_r0), 32'd0);
      chk("stall_res", rsp_res, 32'd0);
      chk("stall_eq", 32'(rsp_flags[4]), 32'd1);
      chk("stall_id", 32'(rsp_id), 32'd1);
    end
    step(1'b0, 1'b1, 4'd0, 32'd9, 32'd9, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("consume_accept0", 32'(last_r0), 32'd1);
    chk("consume_res", rsp_res, 32'd18);

    // Illegal op, then a legal one
    step(1'b0, 1'b1, 4'hC, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("illegal_res", rsp_res, 32'd0);
    chk("illegal_flags", 32'(rsp_flags), 32'd0);
    chk("illegal_err", 32'(rsp_err), 32'd1);
    step(1'b0, 1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("legal_err", 32'(rsp_err), 32'd0);

    // SRA uses only B[4:0]
    step(1'b0, 1'b1, 4'hD, 32'h8000_0000, 32'h21, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("sra_res", rsp_res, 32'hC000_0000);

    // Reset while FULL, consumer stalled, req1 valid
    step(1'b0, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd4, 32'd4, 1'b0);
    chk("rst_full_ready1", 32'(last_r1), 32'd0);
    chk("rst_full_valid", 32'(rsp_valid), 32'd0);
    step(1'b0, 1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 4'd0, 32'd3, 32'd4, 1'b1);
    chk("rst_prio_ready0", 32'(last_r0), 32'd1);
    chk("rst_prio_res", rsp_res, 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      step($urandom_range(0, 39) == 0,
           1'($urandom), 4'($urandom), ra0, rb0,
           1'($urandom), 4'($urandom), ra1, rb1,
           $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
